// File: rtl/md_seq.sv
// md_seq: multi-cycle RV32M multiply/divide sequencer (radix-2 shift-add / restoring divide).
// Define MD_FAST_SPECIAL_EN to resolve divide-by-zero, signed overflow and zero multiplies at accept.
module md_seq #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            start,
    input  logic            kill,
    input  logic [2:0]      op,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int CW = $clog2(XLEN);
    localparam logic [XLEN-1:0] SMIN = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [XLEN-1:0] ALL1 = {XLEN{1'b1}};

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        FIX,
        DONE
    } state_t;

    state_t            state_q;
    logic [2:0]        op_q;
    logic [XLEN-1:0]   a_q;
    logic [XLEN-1:0]   b_q;
    logic [XLEN-1:0]   opnd_q;
    logic [2*XLEN-1:0] acc_q;
    logic              neg_q;
    logic              rneg_q;
    logic [CW-1:0]     cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [XLEN-1:0]   result_q;

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;

    // Returns {hit, value} for the architecturally fixed corner cases.
    function automatic logic [XLEN:0] special_case(input logic [2:0] f,
                                                   input logic [XLEN-1:0] x,
                                                   input logic [XLEN-1:0] y);
        logic [XLEN:0] r;
        r = '0;
        if (f[2]) begin
            if (y == '0)
                r = {1'b1, (f[1] ? x : ALL1)};
            else if (!f[0] && x == SMIN && y == ALL1)
                r = {1'b1, (f[1] ? {XLEN{1'b0}} : SMIN)};
        end else if (x == '0 || y == '0) begin
            r = {1'b1, {XLEN{1'b0}}};
        end
        return r;
    endfunction

    // Operand signedness: MULH both, MULHSU only rs1, DIV/REM both.
    logic            a_signed;
    logic            b_signed;
    logic            sa;
    logic            sb;
    logic [XLEN-1:0] mag_a;
    logic [XLEN-1:0] mag_b;

    assign a_signed = (op == 3'b001) || (op == 3'b010) || (op == 3'b100) || (op == 3'b110);
    assign b_signed = (op == 3'b001) || (op == 3'b100) || (op == 3'b110);
    assign sa       = a_signed & a[XLEN-1];
    assign sb       = b_signed & b[XLEN-1];
    assign mag_a    = sa ? -a : a;
    assign mag_b    = sb ? -b : b;

    // One iteration of each datapath; the carry out of the add lands in bit 63 on the shift.
    logic [XLEN:0]     mul_sum;
    logic [2*XLEN-1:0] mul_next;
    logic [XLEN:0]     rem_sh;
    logic [XLEN:0]     div_diff;
    logic [2*XLEN-1:0] div_next;

    assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : {(XLEN+1){1'b0}});
    assign mul_next = {mul_sum, acc_q[XLEN-1:1]};
    assign rem_sh   = acc_q[2*XLEN-1:XLEN-1];
    assign div_diff = rem_sh - {1'b0, opnd_q};
    assign div_next = div_diff[XLEN] ? {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0}
                                     : {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};

    logic [2*XLEN-1:0] prod_fix;
    logic [XLEN-1:0]   quo_fix;
    logic [XLEN-1:0]   rem_fix;
    logic [XLEN:0]     spec_fix;
    logic [XLEN-1:0]   fix_result;

    assign prod_fix = neg_q  ? -acc_q : acc_q;
    assign quo_fix  = neg_q  ? -acc_q[XLEN-1:0] : acc_q[XLEN-1:0];
    assign rem_fix  = rneg_q ? -acc_q[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
    assign spec_fix = special_case(op_q, a_q, b_q);

    always_comb begin
        fix_result = '0;
        if (spec_fix[XLEN]) begin
            fix_result = spec_fix[XLEN-1:0];
        end else begin
            case (op_q)
                3'b000:                 fix_result = prod_fix[XLEN-1:0];
                3'b001, 3'b010, 3'b011: fix_result = prod_fix[2*XLEN-1:XLEN];
                3'b100, 3'b101:         fix_result = quo_fix;
                default:                fix_result = rem_fix;
            endcase
        end
    end

`ifdef MD_FAST_SPECIAL_EN
    logic [XLEN:0] spec_in;
    assign spec_in = special_case(op, a, b);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            opnd_q   <= '0;
            acc_q    <= '0;
            neg_q    <= 1'b0;
            rneg_q   <= 1'b0;
            cnt_q    <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    done_q <= 1'b0;
                    if (start && !kill) begin
                        op_q   <= op;
                        a_q    <= a;
                        b_q    <= b;
                        cnt_q  <= '0;
                        neg_q  <= sa ^ sb;
                        rneg_q <= sa;
                        // Multiply keeps the multiplier in the low half; divide keeps the dividend there.
                        opnd_q <= op[2] ? mag_b : mag_a;
                        acc_q  <= {{XLEN{1'b0}}, (op[2] ? mag_a : mag_b)};
                        busy_q <= 1'b1;
`ifdef MD_FAST_SPECIAL_EN
                        if (spec_in[XLEN]) begin
                            result_q <= spec_in[XLEN-1:0];
                            done_q   <= 1'b1;
                            state_q  <= DONE;
                        end else begin
                            state_q  <= CALC;
                        end
`else
                        state_q <= CALC;
`endif
                    end
                end
                CALC: begin
                    if (kill) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= op_q[2] ? div_next : mul_next;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == CW'(XLEN - 1))
                            state_q <= FIX;
                    end
                end
                FIX: begin
                    if (kill) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        result_q <= fix_result;
                        done_q   <= 1'b1;
                        state_q  <= DONE;
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

endmodule
